// File: rtl/elem_alu_if.sv
// Operand/result handshake bundle for elem_alu_pipe.
// The flags signal exists only when ELEM_ALU_FLAGS_EN is defined.
interface elem_alu_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic             out_valid;
  logic             out_ready;
`ifdef ELEM_ALU_FLAGS_EN
  logic [1:0]       flags;

  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, c, out_valid, flags
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, c, out_valid, flags
  );
`else
  modport master (
    output a, b, op, in_valid, out_ready,
    input  in_ready, c, out_valid
  );

  modport slave (
    input  a, b, op, in_valid, out_ready,
    output in_ready, c, out_valid
  );
`endif
endinterface

// File: rtl/elem_alu_pipe.sv
// Opcode-selected ALU feeding a STAGES-deep valid/ready register pipeline.
// Define ELEM_ALU_FLAGS_EN to carry {carry, zero} alongside each result.
module elem_alu_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  elem_alu_if.slave bus
);

  localparam int unsigned Last = STAGES - 1;

  typedef enum logic [2:0] {
    OpAnd  = 3'b000,
    OpOr   = 3'b001,
    OpXor  = 3'b010,
    OpAdd  = 3'b011,
    OpSub  = 3'b100,
    OpNot  = 3'b101,
    OpPass = 3'b110,
    OpLt   = 3'b111
  } op_e;

  logic [WIDTH-1:0] res;
  logic             res_carry;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  always_comb begin
    sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
    diff_ext  = {1'b0, bus.a} - {1'b0, bus.b};
    res       = '0;
    res_carry = 1'b0;
    unique case (op_e'(bus.op))
      OpAnd:  res = bus.a & bus.b;
      OpOr:   res = bus.a | bus.b;
      OpXor:  res = bus.a ^ bus.b;
      OpAdd: begin
        res       = sum_ext[WIDTH-1:0];
        res_carry = sum_ext[WIDTH];
      end
      OpSub: begin
        res       = diff_ext[WIDTH-1:0];
        res_carry = diff_ext[WIDTH];  // borrow, i.e. a < b
      end
      OpNot:  res = ~bus.a;
      OpPass: res = bus.b;
      OpLt:   res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
    endcase
  end

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] up_valid;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [WIDTH-1:0]  up_data [STAGES];
`ifdef ELEM_ALU_FLAGS_EN
  logic [1:0]        flags_q  [STAGES];
  logic [1:0]        up_flags [STAGES];
`endif

  // A stage may load when it, or any stage downstream of it, is empty or the
  // consumer is taking the last stage; this is the out_ready -> in_ready chain.
  always_comb begin
    logic room;
    room = bus.out_ready;
    load = '0;
    for (int s = int'(Last); s >= 0; s--) begin
      room    = room | ~valid_q[s];
      load[s] = room;
    end
  end

  always_comb begin
    up_valid    = '0;
    up_data     = '{default: '0};
    up_valid[0] = bus.in_valid;
    up_data[0]  = res;
`ifdef ELEM_ALU_FLAGS_EN
    up_flags    = '{default: '0};
    up_flags[0] = {res_carry, (res == '0)};
`endif
    for (int s = 1; s < int'(STAGES); s++) begin
      up_valid[s] = valid_q[s-1];
      up_data[s]  = data_q[s-1];
`ifdef ELEM_ALU_FLAGS_EN
      up_flags[s] = flags_q[s-1];
`endif
    end
  end

  // Data moves only with a valid token so empty stages keep stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        data_q[s] <= '0;
`ifdef ELEM_ALU_FLAGS_EN
        flags_q[s] <= '0;
`endif
      end
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (load[s]) begin
          valid_q[s] <= up_valid[s];
        end
        if (load[s] && up_valid[s]) begin
          data_q[s] <= up_data[s];
`ifdef ELEM_ALU_FLAGS_EN
          flags_q[s] <= up_flags[s];
`endif
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[Last];
  assign bus.c         = data_q[Last];
`ifdef ELEM_ALU_FLAGS_EN
  assign bus.flags     = flags_q[Last];
`else
  // Carry only matters when flags are carried through the pipeline.
  logic unused_carry;
  assign unused_carry = res_carry;
`endif

endmodule

// File: tb/tb_elem_alu_pipe.sv
// Randomized bench for elem_alu_pipe: three instances (4x2, 16x1, 16x4) share stimulus,
// each with a queue scoreboard fed by an arithmetic reference model.
module tb_elem_alu_pipe;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [15:0] a_drv     = '0;
  logic [15:0] b_drv     = '0;
  logic [2:0]  op_drv    = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          bp_k      = 0;
  int          bp_last   = 0;

`ifdef ELEM_ALU_FLAGS_EN
  localparam logic [17:0] ResMask = 18'h3ffff;
`else
  localparam logic [17:0] ResMask = 18'h0ffff;
`endif

  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {carry, zero, result} for a w-bit unsigned ALU.
  function automatic logic [17:0] model(int unsigned w, logic [15:0] a, logic [15:0] b,
                                        logic [2:0] op);
    longint unsigned modv = 64'd1 << w;
    longint unsigned av   = 64'(a) % modv;
    longint unsigned bv   = 64'(b) % modv;
    longint unsigned r    = 0;
    logic            cy   = 1'b0;
    logic [15:0]     r16;
    case (op)
      3'd0: r = av & bv;
      3'd1: r = av | bv;
      3'd2: r = av ^ bv;
      3'd3: begin r = av + bv; cy = (r >= modv); end
      3'd4: begin r = av + modv - bv; cy = (av < bv); end
      3'd5: r = ~av;
      3'd6: r = bv;
      default: r = (av < bv) ? 64'd1 : 64'd0;
    endcase
    r   = r % modv;
    r16 = r[15:0];
    return {cy, (r == 0), r16};
  endfunction

  function automatic int stg(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  wire [2:0]  ov_w;
  wire [2:0]  ir_w;
  wire [15:0] c_w    [3];
  wire [31:0] acc_w  [3];
  wire [31:0] out_w  [3];
  wire [31:0] serr_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 4 : 16;
    localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    elem_alu_if #(.WIDTH(W)) bus ();

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          acc_cnt   = 0;
    int          out_cnt   = 0;
    int          stall_err = 0;
    logic        stalled   = 1'b0;
    logic [17:0] obs_prev  = '0;
    logic [1:0]  flags_obs;
    wire  [17:0] obs;

    assign bus.a         = a_drv[W-1:0];
    assign bus.b         = b_drv[W-1:0];
    assign bus.op        = op_drv;
    assign bus.in_valid  = in_valid;
    assign bus.out_ready = out_ready;
`ifdef ELEM_ALU_FLAGS_EN
    assign flags_obs = bus.flags;
`else
    assign flags_obs = 2'b00;
`endif
    assign obs       = {flags_obs, 16'(bus.c)};
    assign ov_w[g]   = bus.out_valid;
    assign ir_w[g]   = bus.in_ready;
    assign c_w[g]    = 16'(bus.c);
    assign acc_w[g]  = acc_cnt;
    assign out_w[g]  = out_cnt;
    assign serr_w[g] = stall_err;

    elem_alu_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        exp_q.delete();
        got_q.delete();
        stalled <= 1'b0;
      end else begin
        if (stalled && (!bus.out_valid || obs != obs_prev)) stall_err <= stall_err + 1;
        stalled  <= bus.out_valid && !bus.out_ready;
        obs_prev <= obs;
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(W, a_drv, b_drv, op_drv));
          acc_cnt <= acc_cnt + 1;
        end
        if (bus.out_valid && bus.out_ready) begin
          got_q.push_back(obs);
          out_cnt <= out_cnt + 1;
        end
      end
    end

    function automatic bit pop_pair(output logic [17:0] e, output logic [17:0] o,
                                    output bit extra);
      e = '0;
      o = '0;
      extra = 1'b0;
      if (got_q.size() == 0) return 1'b0;
      o = got_q.pop_front();
      if (exp_q.size() == 0) extra = 1'b1;
      else e = exp_q.pop_front();
      return 1'b1;
    endfunction
  end

  function automatic int pend_n(int i);
    case (i)
      0:       return g_dut[0].exp_q.size();
      1:       return g_dut[1].exp_q.size();
      default: return g_dut[2].exp_q.size();
    endcase
  endfunction

  function automatic int got_n(int i);
    case (i)
      0:       return g_dut[0].got_q.size();
      1:       return g_dut[1].got_q.size();
      default: return g_dut[2].got_q.size();
    endcase
  endfunction

  function automatic logic [17:0] got_at(int i, int k);
    if (k >= got_n(i)) return 18'h3ffff;
    case (i)
      0:       return g_dut[0].got_q[k];
      1:       return g_dut[1].got_q[k];
      default: return g_dut[2].got_q[k];
    endcase
  endfunction

  function automatic bit pop_i(int i, output logic [17:0] e, output logic [17:0] o,
                               output bit ex);
    case (i)
      0:       return g_dut[0].pop_pair(e, o, ex);
      1:       return g_dut[1].pop_pair(e, o, ex);
      default: return g_dut[2].pop_pair(e, o, ex);
    endcase
  endfunction

  task automatic drain_check(string tag);
    logic [17:0] e;
    logic [17:0] o;
    bit          ex;
    for (int i = 0; i < 3; i++) begin
      while (pop_i(i, e, o, ex)) begin
        check_eq($sformatf("%s_u%0d_res", tag, i), 64'(o & ResMask), 64'(e & ResMask));
        if (ex) check_eq($sformatf("%s_u%0d_extra", tag, i), 64'(ex), 64'd0);
      end
      check_eq($sformatf("%s_u%0d_pending", tag, i), 64'(pend_n(i)), 64'd0);
    end
  endtask

  task automatic rand_item();
    a_drv  = 16'($urandom);
    b_drv  = 16'($urandom);
    op_drv = 3'($urandom_range(0, 7));
  endtask

  // Presents items to unit 0 as a proper valid/ready source.
  task automatic bp_step();
    @(negedge clk);
    if (acc_w[0] != bp_last) begin
      bp_last = acc_w[0];
      bp_k++;
      if (bp_k >= 8) in_valid = 1'b0;
      else rand_item();
    end
  endtask

  initial begin
    logic [17:0] o;
    logic [15:0] c_hold;
    int          base_a;
    int          base_o;
    logic [3:0]  sweep_exp [8];
    sweep_exp = '{4'h8, 4'hE, 4'h6, 4'h6, 4'h2, 4'h3, 4'hA, 4'h0};

    // Reset held with traffic offered
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a_drv     = 16'h000C;
    b_drv     = 16'h000A;
    op_drv    = 3'd3;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_ov_u%0d", i), 64'(ov_w[i]), 64'd0);
      check_eq($sformatf("rst_c_u%0d", i), 64'(c_w[i]), 64'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rel_ir_u%0d", i), 64'(ir_w[i]), 64'd1);
      check_eq($sformatf("rel_ov_u%0d", i), 64'(ov_w[i]), 64'd0);
    end

    // Latency: one ADD, out_ready high
    a_drv    = 16'hFFFF;
    b_drv    = 16'h0002;
    op_drv   = 3'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("lat_u%0d_e%0d", i, j), 64'(ov_w[i]), 64'(j == stg(i) - 1));
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      o = got_at(i, 0);
      check_eq($sformatf("lat_add_u%0d", i), 64'(o[15:0]), 64'h1);
    end
    drain_check("lat");

    // Op sweep
    a_drv    = 16'h000C;
    b_drv    = 16'h000A;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op_drv = 3'(k);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      o = got_at(0, k);
      check_eq($sformatf("sweep_op%0d", k), 64'(o[3:0]), 64'(sweep_exp[k]));
    end
    drain_check("sweep");

    // Wrap and flags
    in_valid = 1'b1;
    a_drv    = 16'h000F;
    b_drv    = 16'h0001;
    op_drv   = 3'd3;
    @(negedge clk);
    a_drv    = 16'h0003;
    b_drv    = 16'h0005;
    op_drv   = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    o = got_at(0, 0);
    check_eq("wrap_add_c", 64'(o[3:0]), 64'h0);
`ifdef ELEM_ALU_FLAGS_EN
    check_eq("wrap_add_flags", 64'(o[17:16]), 64'h3);
`endif
    o = got_at(0, 1);
    check_eq("wrap_sub_c", 64'(o[3:0]), 64'hE);
`ifdef ELEM_ALU_FLAGS_EN
    check_eq("wrap_sub_flags", 64'(o[17:16]), 64'h2);
`endif
    drain_check("wrap");

    // Backpressure on unit 0
    out_ready = 1'b0;
    bp_k      = 0;
    bp_last   = acc_w[0];
    base_a    = acc_w[0];
    rand_item();
    in_valid  = 1'b1;
    repeat (6) bp_step();
    check_eq("bp_accepted", 64'(acc_w[0] - base_a), 64'd2);
    check_eq("bp_in_ready", 64'(ir_w[0]), 64'd0);
    c_hold = c_w[0];
    repeat (3) bp_step();
    check_eq("bp_c_stable", 64'(c_w[0]), 64'(c_hold));
    check_eq("bp_ov_held", 64'(ov_w[0]), 64'd1);
    out_ready = 1'b1;
    base_o    = out_w[0];
    repeat (8) bp_step();
    check_eq("bp_outputs", 64'(out_w[0] - base_o), 64'd8);
    check_eq("bp_total_acc", 64'(acc_w[0] - base_a), 64'd8);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    drain_check("bp");

    // Mid-flight asynchronous reset
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_item();
    @(negedge clk);
    rand_item();
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("mf_pre_ov", 64'(ov_w[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check_eq($sformatf("mf_ov_u%0d", i), 64'(ov_w[i]), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("mf_post_ov_u%0d", i), 64'(ov_w[i]), 64'd0);
      check_eq($sformatf("mf_stale_u%0d", i), 64'(got_n(i)), 64'd0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_item();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) > 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    drain_check("rand");
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stall_hold_u%0d", i), 64'(serr_w[i]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
